// File: rtl/res_readout.sv
// Result-memory scanner: reads NPIX pixels in address order through a 2-entry buffer,
// streams them out over valid/ready and accumulates a checksum and a nonzero-pixel count.
module res_readout #(
    parameter int NPIX = 16384,
    parameter int AW   = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          res_rd,
    output logic [AW-1:0] res_addr,
    input  logic [7:0]    res_di,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic [AW-1:0] out_addr,
    output logic          busy,
    output logic          done,
    output logic [15:0]   checksum,
    output logic [AW:0]   nz_count
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [AW-1:0] LastAddr = AW'(NPIX - 1);

    state_t             state_q, state_d;
    logic               res_rd_q, res_rd_d;
    logic [AW-1:0]      res_addr_q, res_addr_d;
    logic [AW-1:0]      nextAddr_q, nextAddr_d;
    logic               pend_q, pend_d;
    logic [AW-1:0]      pendAddr_q, pendAddr_d;
    logic [1:0][7:0]    bufData_q, bufData_d;
    logic [1:0][AW-1:0] bufAddr_q, bufAddr_d;
    logic               wrIdx_q, wrIdx_d;
    logic               rdIdx_q, rdIdx_d;
    logic [1:0]         count_q, count_d;
    logic [15:0]        checksum_q, checksum_d;
    logic [AW:0]        nzCount_q, nzCount_d;
    logic               beat;
    logic               lastIssued;
    logic               canIssue;

    always_comb begin
        state_d    = state_q;
        res_rd_d   = 1'b0;
        res_addr_d = res_addr_q;
        nextAddr_d = nextAddr_q;
        bufData_d  = bufData_q;
        bufAddr_d  = bufAddr_q;
        wrIdx_d    = wrIdx_q;
        rdIdx_d    = rdIdx_q;
        checksum_d = checksum_q;
        nzCount_d  = nzCount_q;

        beat       = (count_q != 2'd0) && out_ready;
        lastIssued = res_rd_q && (res_addr_q == LastAddr);

        // The read driven this cycle returns data one cycle later; track it as pending.
        pend_d     = res_rd_q;
        pendAddr_d = res_rd_q ? res_addr_q : pendAddr_q;

        if (pend_q) begin
            bufData_d[wrIdx_q] = res_di;
            bufAddr_d[wrIdx_q] = pendAddr_q;
            wrIdx_d            = ~wrIdx_q;
        end
        if (beat) begin
            rdIdx_d    = ~rdIdx_q;
            checksum_d = checksum_q + {8'h00, bufData_q[rdIdx_q]};
            if (bufData_q[rdIdx_q] != 8'h00) begin
                nzCount_d = nzCount_q + (AW+1)'(1);
            end
        end
        count_d = count_q + {1'b0, pend_q} - {1'b0, beat};

        // A new read is allowed only if every unaccepted pixel, it included, has a buffer slot.
        canIssue = (count_d + {1'b0, res_rd_q}) < 2'd2;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    res_rd_d   = 1'b1;
                    res_addr_d = '0;
                    nextAddr_d = AW'(1);
                    pend_d     = 1'b0;
                    count_d    = 2'd0;
                    wrIdx_d    = 1'b0;
                    rdIdx_d    = 1'b0;
                    checksum_d = 16'h0000;
                    nzCount_d  = '0;
                end
            end
            RUN: begin
                if (lastIssued) begin
                    state_d = FLUSH;
                end else if (canIssue) begin
                    res_rd_d   = 1'b1;
                    res_addr_d = nextAddr_q;
                    nextAddr_d = nextAddr_q + AW'(1);
                end
            end
            FLUSH: begin
                if ((count_d == 2'd0) && !pend_d) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            res_rd_q   <= 1'b0;
            res_addr_q <= '0;
            nextAddr_q <= '0;
            pend_q     <= 1'b0;
            pendAddr_q <= '0;
            bufData_q  <= '0;
            bufAddr_q  <= '0;
            wrIdx_q    <= 1'b0;
            rdIdx_q    <= 1'b0;
            count_q    <= 2'd0;
            checksum_q <= 16'h0000;
            nzCount_q  <= '0;
        end else begin
            state_q    <= state_d;
            res_rd_q   <= res_rd_d;
            res_addr_q <= res_addr_d;
            nextAddr_q <= nextAddr_d;
            pend_q     <= pend_d;
            pendAddr_q <= pendAddr_d;
            bufData_q  <= bufData_d;
            bufAddr_q  <= bufAddr_d;
            wrIdx_q    <= wrIdx_d;
            rdIdx_q    <= rdIdx_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            nzCount_q  <= nzCount_d;
        end
    end

    assign res_rd    = res_rd_q;
    assign res_addr  = res_addr_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = bufData_q[rdIdx_q];
    assign out_addr  = bufAddr_q[rdIdx_q];
    assign busy      = (state_q == RUN) || (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign checksum  = checksum_q;
    assign nz_count  = nzCount_q;

endmodule

// File: tb/tb_res_readout.sv
// Directed bench for res_readout: table of full scans with expected totals, plus
// hand-written stall, mid-run reset and ignored-restart sequences.
`timescale 1ns/1ps
module tb_res_readout;

    localparam int NPIX = 512;
    localparam int AW   = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          res_rd;
    logic [AW-1:0] res_addr;
    logic [7:0]    memData = 8'h00;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [AW-1:0] out_addr;
    logic          busy;
    logic          done;
    logic [15:0]   checksum;
    logic [AW:0]   nz_count;

    logic [7:0]    mem [NPIX];
    int            checks = 0;
    int            passes = 0;

    typedef struct {
        int          pat;
        int          mode;
        logic [15:0] expSum;
        int          expNz;
    } vec_t;

    vec_t vecs [4];

    res_readout #(.NPIX(NPIX), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .res_rd(res_rd), .res_addr(res_addr), .res_di(memData),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done), .checksum(checksum), .nz_count(nz_count)
    );

    always #5 clk = ~clk;

    // Synchronous result memory: data for a read appears the cycle after res_rd.
    always @(posedge clk) begin
        if (res_rd) memData <= mem[res_addr];
    end

    function automatic logic [7:0] patVal(input int pat, input int i);
        case (pat)
            0:       return 8'(i % 256);
            1:       return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic applyStimulus(input logic st, input logic rdy, input logic rst);
        start     = st;
        out_ready = rdy;
        reset     = rst;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkResetValues();
        checkOutput("rst res_rd", res_rd, 0);
        checkOutput("rst res_addr", res_addr, 0);
        checkOutput("rst out_valid", out_valid, 0);
        checkOutput("rst out_data", out_data, 0);
        checkOutput("rst out_addr", out_addr, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst checksum", checksum, 0);
        checkOutput("rst nz_count", nz_count, 0);
    endtask

    // mode: 0 ready always, 1 ready random, 2 ready low for the first 20 cycles.
    task automatic runScan(input int pat, input int mode, input int restartAt,
                           input int resetAt, input logic [15:0] expSum, input int expNz);
        int   beats = 0;
        int   reads = 0;
        int   cyc = 0;
        int   lastBeatCyc = -10;
        logic rdy;
        logic prevStall = 1'b0;
        logic [7:0] prevData = 8'h00;
        logic [AW-1:0] prevAddr = '0;
        bit   finished = 0;
        bit   resetHit = 0;

        for (int i = 0; i < NPIX; i++) mem[i] = patVal(pat, i);
        @(negedge clk);
        applyStimulus(1'b1, mode == 0, 1'b0);
        @(negedge clk);
        while (!finished && !resetHit && cyc < 5000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc >= 20);
            applyStimulus(restartAt == cyc, rdy, 1'b0);
            if (prevStall) begin
                checkOutput("stall valid", out_valid, 1);
                checkOutput("stall data", out_data, prevData);
                checkOutput("stall addr", out_addr, prevAddr);
            end
            if (res_rd) begin
                checkOutput("read addr", res_addr, reads);
                reads++;
                checkOutput("pending<=2", (reads - beats) <= 2, 1);
            end
            if (mode == 2 && cyc == 19) begin
                checkOutput("stalled read count", reads, 2);
                checkOutput("stalled valid", out_valid, 1);
                checkOutput("stalled first addr", out_addr, 0);
                checkOutput("stalled res_rd", res_rd, 0);
            end
            if (out_valid && rdy) begin
                checkOutput("beat addr", out_addr, beats);
                checkOutput("beat data", out_data, patVal(pat, beats));
                beats++;
                lastBeatCyc = cyc;
            end
            if (done) begin
                checkOutput("done after last beat", cyc - lastBeatCyc, 1);
                finished = 1;
            end
            prevStall = out_valid && !rdy;
            prevData  = out_data;
            prevAddr  = out_addr;
            if (resetAt >= 0 && res_rd && res_addr == AW'(resetAt)) begin
                applyStimulus(1'b0, rdy, 1'b1);
                @(negedge clk);
                checkResetValues();
                applyStimulus(1'b0, 1'b1, 1'b0);
                @(negedge clk);
                checkOutput("post-reset data discarded", out_valid, 0);
                checkOutput("post-reset idle", busy, 0);
                resetHit = 1;
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        if (!resetHit) begin
            checkOutput("scan finished in budget", finished, 1);
            checkOutput("beat count", beats, NPIX);
            checkOutput("read count", reads, NPIX);
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1'b0, 1'b1, 1'b0);
                checkOutput("done single pulse", done, 0);
                checkOutput("idle busy", busy, 0);
                checkOutput("idle res_rd", res_rd, 0);
                checkOutput("checksum", checksum, expSum);
                checkOutput("nz_count", nz_count, expNz);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        vecs[0] = '{pat: 0, mode: 0, expSum: 16'hFF00, expNz: 510};
        vecs[1] = '{pat: 0, mode: 1, expSum: 16'hFF00, expNz: 510};
        vecs[2] = '{pat: 1, mode: 0, expSum: 16'h0000, expNz: 0};
        vecs[3] = '{pat: 2, mode: 1, expSum: 16'hFE00, expNz: 512};

        applyStimulus(1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        checkResetValues();
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("idle after reset", busy, 0);

        for (int v = 0; v < 4; v++) begin
            $display("[TB] scan vector %0d", v);
            runScan(vecs[v].pat, vecs[v].mode, -1, -1, vecs[v].expSum, vecs[v].expNz);
        end

        $display("[TB] stall after start");
        runScan(0, 2, -1, -1, 16'hFF00, 510);

        $display("[TB] reset mid-run then rescan");
        runScan(0, 0, -1, 300, 16'h0000, 0);
        runScan(0, 0, -1, -1, 16'hFF00, 510);

        $display("[TB] start pulsed during run");
        runScan(0, 0, 100, -1, 16'hFF00, 510);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
